// File: rtl/cache_pkg.sv
// Shared definitions for the cache line refill engine: FSM state type,
// the line status written on a fill, and the block-offset width helper.
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WB   = 2'd1,
    RD   = 2'd2,
    FILL = 2'd3
  } refill_state_t;

  // Status written with every freshly filled line: valid, not dirty.
  localparam logic [2:0] STAT_VALID_CLEAN = 3'b001;

  // Number of word-offset bits in a line of block_size 32-bit words.
  function automatic int block_pos_of(input int block_size);
    return $clog2(block_size);
  endfunction

endpackage

// File: rtl/cache_line_buf.sv
// Line assembly register for the refill engine: one 32-bit word slot per
// beat, each slot written only when its own word enable is active.
module cache_line_buf #(
  parameter int BLOCK_SIZE = 8,
  parameter int SEL_WIDTH  = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_en,
  input  logic [SEL_WIDTH-1:0]    word_sel,
  input  logic [31:0]             wdata,
  output logic [32*BLOCK_SIZE-1:0] block
);

  logic [BLOCK_SIZE-1:0] word_we;

  // Decode the beat index into one write enable per word slot.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    word_we = '0;
    for (int i = 0; i < BLOCK_SIZE; i++) begin
      word_we[i] = wr_en && (word_sel == SEL_WIDTH'(i));
    end
  end

  // Capture returning read data into the selected slot; other slots hold.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: this buffer is a small register array, not a RAM, so it takes the reset and reads 0 afterwards.
    if (!rst_n) begin
      // NOTE: state is updated with non-blocking assignments so all flops see pre-edge values.
      block <= '0;
    end else begin
      for (int i = 0; i < BLOCK_SIZE; i++) begin
        if (word_we[i]) block[32*i +: 32] <= wdata;
      end
    end
  end

endmodule

// File: rtl/cache_refill.sv
// Cache miss refill engine: optional write-back of a dirty victim line
// followed by a burst read of the missing line, then a one-cycle fill strobe.
// Optional feature macro: CACHE_WB_EN enables the victim write-back phase;
// without it every miss goes straight to the read burst and mem_we stays 0.
module cache_refill
  import cache_pkg::*;
#(
  parameter  int CACHE_SIZE  = 12,
  parameter  int BLOCK_SIZE  = 8,
  parameter  int STAT_WIDTH  = 3,
  localparam int BLOCK_WIDTH = 32 * BLOCK_SIZE,
  localparam int TAG_WIDTH   = 32 - CACHE_SIZE
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   miss_req,
  input  logic [31:0]            miss_addr,
  input  logic                   victim_dirty,
  input  logic [TAG_WIDTH-1:0]   victim_tag,
  input  logic [BLOCK_WIDTH-1:0] victim_block,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic [31:0]            mem_addr,
  output logic [31:0]            mem_wdata,
  input  logic [31:0]            mem_rdata,
  input  logic                   mem_ack,
  output logic                   fill_wr,
  output logic [TAG_WIDTH-1:0]   fill_tag,
  output logic [STAT_WIDTH-1:0]  fill_status,
  output logic [BLOCK_WIDTH-1:0] fill_block,
  output logic                   busy,
  output logic                   done
);

  localparam int BLOCK_POS = block_pos_of(BLOCK_SIZE);
  localparam int IDX_WIDTH = CACHE_SIZE - BLOCK_POS - 2;
  // A single-word line still needs a (constant zero) beat counter.
  localparam int CNT_WIDTH = (BLOCK_POS == 0) ? 1 : BLOCK_POS;

  refill_state_t        state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [TAG_WIDTH-1:0] miss_tag_q;
  logic [IDX_WIDTH-1:0] idx_q;
  logic [TAG_WIDTH-1:0] beat_tag;
  logic                 last_beat;
  logic                 beat_done;

  assign last_beat = (cnt_q == CNT_WIDTH'(BLOCK_SIZE - 1));
  assign beat_done = mem_req && mem_ack;

  // Word offset bits of the miss address are replaced by the beat counter.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^miss_addr[BLOCK_POS+1:0];

  // State register, beat counter and miss address latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      miss_tag_q <= '0;
      idx_q      <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && miss_req) begin
        miss_tag_q <= miss_addr[31:CACHE_SIZE];
        idx_q      <= miss_addr[CACHE_SIZE-1:BLOCK_POS+2];
      end
      if (state_d != state_q) cnt_q <= '0;
      else if (beat_done)     cnt_q <= cnt_q + CNT_WIDTH'(1);
    end
  end

`ifdef CACHE_WB_EN
  logic [TAG_WIDTH-1:0]   victim_tag_q;
  logic [BLOCK_WIDTH-1:0] victim_q;

  // Victim line latch, captured together with the miss address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      victim_tag_q <= '0;
      victim_q     <= '0;
    end else if (state_q == IDLE && miss_req) begin
      victim_tag_q <= victim_tag;
      victim_q     <= victim_block;
    end
  end
`else
  logic unused_victim;
  assign unused_victim = ^{victim_dirty, victim_tag, victim_block};
`endif

  // Next-state decode and all memory/fill outputs.
  always_comb begin
    state_d     = state_q;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_wdata   = '0;
    fill_wr     = 1'b0;
    fill_tag    = '0;
    fill_status = '0;
    busy        = 1'b0;
    done        = 1'b0;
    beat_tag    = miss_tag_q;
    case (state_q)
      IDLE: begin
        if (miss_req) begin
`ifdef CACHE_WB_EN
          state_d = victim_dirty ? WB : RD;
`else
          state_d = RD;
`endif
        end
      end
`ifdef CACHE_WB_EN
      WB: begin
        busy      = 1'b1;
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        beat_tag  = victim_tag_q;
        mem_wdata = victim_q[{cnt_q, 5'b00000} +: 32];
        if (mem_ack && last_beat) state_d = RD;
      end
`endif
      RD: begin
        busy    = 1'b1;
        mem_req = 1'b1;
        if (mem_ack && last_beat) state_d = FILL;
      end
      FILL: begin
        busy        = 1'b1;
        fill_wr     = 1'b1;
        done        = 1'b1;
        fill_tag    = miss_tag_q;
        fill_status = STAT_WIDTH'(STAT_VALID_CLEAN);
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
    mem_addr = mem_req
             ? ({beat_tag, idx_q, {(BLOCK_POS + 2){1'b0}}} | 32'({cnt_q, 2'b00}))
             : '0;
  end

  cache_line_buf #(
    .BLOCK_SIZE (BLOCK_SIZE),
    .SEL_WIDTH  (CNT_WIDTH)
  ) u_line_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (state_q == RD && mem_ack),
    .word_sel (cnt_q),
    .wdata    (mem_rdata),
    .block    (fill_block)
  );

endmodule

// File: tb/tb_cache_refill.sv
// Directed self-checking bench for cache_refill (default parameters).
module tb_cache_refill;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         miss_req;
  logic [31:0]  miss_addr;
  logic         victim_dirty;
  logic [19:0]  victim_tag;
  logic [255:0] victim_block;
  logic         mem_req, mem_we;
  logic [31:0]  mem_addr, mem_wdata, mem_rdata;
  logic         mem_ack;
  logic         fill_wr;
  logic [19:0]  fill_tag;
  logic [2:0]   fill_status;
  logic [255:0] fill_block;
  logic         busy, done;

  cache_refill dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .miss_req     (miss_req),
    .miss_addr    (miss_addr),
    .victim_dirty (victim_dirty),
    .victim_tag   (victim_tag),
    .victim_block (victim_block),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_ack      (mem_ack),
    .fill_wr      (fill_wr),
    .fill_tag     (fill_tag),
    .fill_status  (fill_status),
    .fill_block   (fill_block),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Memory responder: ack after ack_delay waiting cycles, or always when forced.
  logic        ack_force = 1'b1;
  int          ack_delay = 0;
  int          wait_cnt  = 0;
  logic [31:0] rd_base   = '0;
  assign mem_ack   = ack_force | (mem_req && (wait_cnt == ack_delay));
  assign mem_rdata = rd_base + {27'd0, mem_addr[4:2]};
  always @(posedge clk) begin
    if (mem_req && !mem_ack) wait_cnt <= wait_cnt + 1;
    else                     wait_cnt <= 0;
  end

  // Bus / fill monitor, sampled on the falling edge.
  logic [31:0]  log_addr [64];
  logic         log_we   [64];
  logic [31:0]  log_wdata[64];
  int           n_beats, n_fill, n_done, n_we;
  logic [19:0]  last_tag;
  logic [2:0]   last_stat;
  logic [255:0] last_block;
  logic         stable_ok, prev_wait, prev_we;
  logic [31:0]  prev_addr, prev_wdata;

  task automatic clear_log();
    n_beats = 0; n_fill = 0; n_done = 0; n_we = 0;
    stable_ok = 1'b1; prev_wait = 1'b0;
    last_tag = '0; last_stat = '0; last_block = '0;
  endtask

  always @(negedge clk) begin
    if (mem_req && mem_ack && n_beats < 64) begin
      log_addr[n_beats]  = mem_addr;
      log_we[n_beats]    = mem_we;
      log_wdata[n_beats] = mem_wdata;
      n_beats++;
    end
    if (mem_we) n_we++;
    if (done) n_done++;
    if (fill_wr) begin
      n_fill++;
      last_tag   = fill_tag;
      last_stat  = fill_status;
      last_block = fill_block;
    end
    if (prev_wait && mem_req &&
        (mem_addr !== prev_addr || mem_wdata !== prev_wdata || mem_we !== prev_we))
      stable_ok = 1'b0;
    prev_wait  = mem_req && !mem_ack;
    prev_addr  = mem_addr;
    prev_wdata = mem_wdata;
    prev_we    = mem_we;
  end

  // Issue one miss; lat is the cycle done is seen, counting the miss_req cycle as 1.
  // Extra miss_req pulses are driven in cycles p1 and p2 of the burst (0 = none).
  task automatic run_miss(input logic [31:0] addr, input logic dirty, input logic [19:0] vtag,
                          input logic [255:0] vblk, input int p1, input int p2, output int lat);
    @(posedge clk); #1;
    clear_log();
    @(negedge clk);
    miss_addr = addr; victim_dirty = dirty; victim_tag = vtag; victim_block = vblk;
    miss_req = 1'b1;
    lat = 1;
    @(negedge clk);
    lat = 2;
    // Inputs change after capture; the engine must use its latched copies.
    miss_addr = 32'hFFFF_FFFF; victim_tag = 20'hFFFFF; victim_block = '1; victim_dirty = 1'b1;
    miss_req = (lat == p1) || (lat == p2);
    while (!done && lat < 200) begin
      @(negedge clk);
      lat++;
      miss_req = (lat == p1) || (lat == p2);
    end
    miss_req = 1'b0;
    check("done_seen", done, 1'b1);
    repeat (2) @(negedge clk);
  endtask

  logic [255:0] exp_blk, vblk;
  int           lat;

  initial begin
    rst_n = 1'b1; miss_req = 1'b0; miss_addr = '0;
    victim_dirty = 1'b0; victim_tag = '0; victim_block = '0;
    clear_log();
    #2 rst_n = 1'b0;
    #1;
    check("rst_ctrl", {mem_req, mem_we, fill_wr, done, busy}, 5'b0);
    check("rst_addr", {mem_addr, mem_wdata}, 64'd0);
    check("rst_fill", {fill_tag, fill_status}, 23'd0);
    check("rst_block", fill_block, 256'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Clean miss, zero-wait memory, read data = beat index.
    ack_force = 1'b1; rd_base = 32'h0;
    run_miss(32'h0000_1A20, 1'b0, 20'h0, 256'd0, 0, 0, lat);
    check("clean_lat", lat, 10);
    check("clean_beats", n_beats, 8);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("clean_addr%0d", k), log_addr[k], 32'h1A20 + 4 * k);
      check($sformatf("clean_we%0d", k), log_we[k], 1'b0);
    end
    for (int k = 0; k < 8; k++) exp_blk[32*k +: 32] = k;
    check("clean_nfill", n_fill, 1);
    check("clean_ndone", n_done, 1);
    check("clean_tag", last_tag, 20'h00001);
    check("clean_stat", last_stat, 3'b001);
    check("clean_block", last_block, exp_blk);
    repeat (3) @(negedge clk);
    check("clean_idle", {busy, mem_req, fill_wr}, 3'b0);
    check("clean_hold", fill_block, exp_blk);

    // Dirty miss with victim words 0x100+k.
    for (int k = 0; k < 8; k++) vblk[32*k +: 32] = 32'h100 + k;
    rd_base = 32'hA000_0000;
    run_miss(32'h0000_5020, 1'b1, 20'h0ABCD, vblk, 0, 0, lat);
    for (int k = 0; k < 8; k++) exp_blk[32*k +: 32] = 32'hA000_0000 + k;
`ifdef CACHE_WB_EN
    check("dirty_lat", lat, 18);
    check("dirty_beats", n_beats, 16);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("wb_addr%0d", k), log_addr[k], 32'h0ABC_D020 + 4 * k);
      check($sformatf("wb_we%0d", k), log_we[k], 1'b1);
      check($sformatf("wb_data%0d", k), log_wdata[k], 32'h100 + k);
      check($sformatf("rd_addr%0d", k), log_addr[k+8], 32'h5020 + 4 * k);
      check($sformatf("rd_we%0d", k), log_we[k+8], 1'b0);
    end
`else
    check("nowb_lat", lat, 10);
    check("nowb_beats", n_beats, 8);
    check("nowb_we", n_we, 0);
    for (int k = 0; k < 8; k++)
      check($sformatf("nowb_addr%0d", k), log_addr[k], 32'h5020 + 4 * k);
`endif
    check("dirty_nfill", n_fill, 1);
    check("dirty_tag", last_tag, 20'h00005);
    check("dirty_block", last_block, exp_blk);
    repeat (3) @(negedge clk);
    check("dirty_hold", fill_block, exp_blk);

    // Slow memory: three wait cycles before every ack.
    ack_force = 1'b0; ack_delay = 3; rd_base = 32'h5500_0000;
    run_miss(32'h0000_2FE0, 1'b0, 20'h0, 256'd0, 0, 0, lat);
    check("slow_lat", lat, 34);
    check("slow_stable", stable_ok, 1'b1);
    check("slow_beats", n_beats, 8);
    check("slow_addr7", log_addr[7], 32'h2FFC);
    check("slow_tag", last_tag, 20'h00002);
    check("slow_word5", last_block[32*5 +: 32], 32'h5500_0005);

    // miss_req pulses inside the burst must be ignored.
    ack_force = 1'b1; ack_delay = 0; rd_base = 32'h0;
    run_miss(32'h0000_3040, 1'b0, 20'h0, 256'd0, 2, 5, lat);
    check("pulse_lat", lat, 10);
    repeat (12) @(negedge clk);
    check("pulse_nfill", n_fill, 1);
    check("pulse_ndone", n_done, 1);
    check("pulse_beats", n_beats, 8);
    check("pulse_tag", last_tag, 20'h00003);
    check("pulse_busy", busy, 1'b0);

    // Reset during RD beat 4 abandons the burst.
    @(posedge clk); #1;
    clear_log();
    @(negedge clk);
    miss_addr = 32'h0000_7040; victim_dirty = 1'b0; miss_req = 1'b1;
    @(negedge clk);
    miss_req = 1'b0;
    for (int i = 0; i < 50 && mem_addr !== 32'h7050; i++) @(negedge clk);
    check("rstmid_reach", mem_addr, 32'h7050);
    #2 rst_n = 1'b0;
    #1;
    check("rstmid_req", {mem_req, busy, fill_wr, done}, 4'b0);
    check("rstmid_addr", mem_addr, 32'h0);
    check("rstmid_block", fill_block, 256'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("rstmid_nfill", n_fill, 0);
    check("rstmid_ndone", n_done, 0);
    check("rstmid_idle", {busy, mem_req}, 2'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
